mux_2to1_arb: RTL and testbench
===============================

// Module: mux_2to1_arb
// PURPOSE
//  Arbiter/sequencer for the shared 2:1 mux datapath (S0=0 selects A, S0=1 selects B).
//  Two requesters (A, B) offer WIDTH-bit beats via valid/ready; the block grants one
//  at a time, drives S0, and registers the selected beat onto a single Z valid/ready port.
//  Round-robin arbitration with a burst limit so neither side starves the other.
// PARAMETERS
//  WIDTH      1  data width of A_DATA, B_DATA, Z_DATA
//  MAX_BURST  4  max beats accepted per grant before re-arbitration (>=1)
// PORTS
//  CLK        in   1          single clock, rising edge
//  RST_N      in   1          reset, asynchronous, active-low
//  A_VALID    in   1          requester A has a beat
//  A_READY    out  1          A beat accepted this cycle when A_VALID&A_READY
//  A_DATA     in   WIDTH      requester A beat
//  B_VALID    in   1          requester B has a beat
//  B_READY    out  1          B beat accepted this cycle when B_VALID&B_READY
//  B_DATA     in   WIDTH      requester B beat
//  Z_VALID    out  1          registered output beat valid
//  Z_READY    in   1          downstream accepts Z beat when Z_VALID&Z_READY
//  Z_DATA     out  WIDTH      registered output beat
//  S0         out  1          registered mux select: 0=A granted/last, 1=B
// BEHAVIOUR
//  Reset (async, RST_N=0): state=IDLE, S0=0, Z_VALID=0, Z_DATA=0, burst count=0,
//   LAST=1 (so A wins first contention). A_READY=B_READY=0. Applies mid-burst; in-flight
//   Z beat is dropped.
//  load_en = !Z_VALID | Z_READY (single output register, no skid buffer).
//  A_READY = load_en & (state==GRANT_A); B_READY = load_en & (state==GRANT_B). Comb.
//  Accepted beat: Z_DATA<=selected data, Z_VALID<=1 next edge (latency 1 cycle).
//  If load_en & no beat accepted: Z_VALID<=0. Otherwise Z_VALID/Z_DATA hold.
//  States: IDLE, GRANT_A, GRANT_B (registered; READY never asserted in IDLE).
//   IDLE: both valid -> GRANT of side !=LAST; one valid -> that side; none -> stay.
//    First READY one cycle after VALID rises from IDLE.
//   GRANT_x: each accepted beat increments count. Leave grant when x_VALID=0, or
//    a beat is accepted with count==MAX_BURST-1. On leave: other side valid -> GRANT_other
//    directly (no IDLE bubble); else x still valid (burst end) -> stay GRANT_x, count=0;
//    else IDLE. LAST<=x on leaving. Count clears on every grant change/restart.
//   x_VALID dropping while Z stalled (load_en=0) still releases the grant.
//  S0 updates on the same edge as state: 0 in GRANT_A, 1 in GRANT_B, holds in IDLE.
//  Z_DATA must equal the beat from the side indicated by S0 at accept time.
//  Count width = $clog2(MAX_BURST)+1; MAX_BURST=1 alternates every beat under contention.
// CONFIGURATION
//  FIXED_PRIO_EN defined: A wins every contention (IDLE and grant exit), LAST ignored;
//   burst limit still applies, so B may starve while A stays valid (intended).
//  FIXED_PRIO_EN undefined: round-robin via LAST as above.
// TESTING
//  1 Reset: RST_N=0 mid-burst -> immediately S0=0, Z_VALID=0, A_READY=B_READY=0.
//  2 A only, A_VALID=1 data 1,0,1,1,0, Z_READY=1 -> A_READY from cycle 2, Z_DATA
//    1,0,1,1,0 one cycle behind, S0=0, stays GRANT_A across burst restart.
//  3 Both valid continuously, Z_READY=1, MAX_BURST=4 -> 4 A beats, 4 B beats, repeat;
//    S0 toggles every 4 beats, no idle cycle on Z.
//  4 Backpressure: Z_READY=0 for 3 cycles with Z_VALID=1 -> A_READY=0, Z_DATA held,
//    no beat lost or duplicated after Z_READY=1.
//  5 B grant, B_VALID drops after 2 beats, A_VALID=1 -> GRANT_A next edge, S0=1->0.
//  6 FIXED_PRIO_EN: both valid, MAX_BURST=4 -> A granted after every burst, B_READY
//    never 1 while A_VALID=1.

Source files
------------

// File: rtl/mux_2to1_arb.sv
// -----------------------------------------------------------------------------
// mux_2to1_arb
//
// Arbiter/sequencer for a shared 2:1 mux datapath. Two requesters (A, B) offer
// beats over valid/ready. One side is granted at a time. S0 steers the mux
// (0 = A, 1 = B). The selected beat is registered onto a single Z valid/ready
// port with one cycle of latency.
//
// Arbitration is round-robin with a burst limit. After MAX_BURST accepted
// beats, the grant is re-arbitrated so that neither side starves the other.
//
// Optional feature (compile-time macro FIXED_PRIO_EN):
//   Defined   : A wins every contention, both from IDLE and at grant exit.
//               The burst limit still applies, so B may starve while A stays
//               valid.
//   Undefined : round-robin using the LAST indicator.
//
// Parameters
//   WIDTH      data width of A_DATA, B_DATA, Z_DATA
//   MAX_BURST  max beats accepted per grant before re-arbitration (>= 1)
//
// Ports
//   CLK      in   rising-edge clock
//   RST_N    in   asynchronous active-low reset
//   A_VALID  in   requester A has a beat
//   A_READY  out  A beat accepted when A_VALID & A_READY
//   A_DATA   in   requester A beat
//   B_VALID  in   requester B has a beat
//   B_READY  out  B beat accepted when B_VALID & B_READY
//   B_DATA   in   requester B beat
//   Z_VALID  out  registered output beat valid
//   Z_READY  in   downstream accepts Z beat when Z_VALID & Z_READY
//   Z_DATA   out  registered output beat
//   S0       out  registered mux select (0 = A granted/last, 1 = B)
// -----------------------------------------------------------------------------
module mux_2to1_arb #(
  parameter int WIDTH     = 1,
  parameter int MAX_BURST = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             A_VALID,
  output logic             A_READY,
  input  logic [WIDTH-1:0] A_DATA,
  input  logic             B_VALID,
  output logic             B_READY,
  input  logic [WIDTH-1:0] B_DATA,
  output logic             Z_VALID,
  input  logic             Z_READY,
  output logic [WIDTH-1:0] Z_DATA,
  output logic             S0
);

  localparam int CW = $clog2(MAX_BURST) + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_A = 2'd1;
  localparam logic [1:0] GRANT_B = 2'd2;

  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_q, last_d;   // side granted most recently: 0 = A, 1 = B
  logic          s0_d;
  logic          load_en;
  logic          accept_a, accept_b;
  logic          a_wins_tie;

  // The single output register can take a new beat when it is empty or
  // draining this cycle. There is no skid buffer.
  assign load_en  = !Z_VALID || Z_READY;
  assign A_READY  = load_en && (state_q == GRANT_A);
  assign B_READY  = load_en && (state_q == GRANT_B);
  assign accept_a = A_VALID && A_READY;
  assign accept_b = B_VALID && B_READY;

`ifdef FIXED_PRIO_EN
  assign a_wins_tie = 1'b1;
`else
  // LAST = 1 means B went last, so A gets the next contention.
  assign a_wins_tie = last_q;
`endif

  // NOTE: every signal driven here gets a default first, so that no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        count_d = '0;
        if (A_VALID && B_VALID) state_d = a_wins_tie ? GRANT_A : GRANT_B;
        else if (A_VALID)       state_d = GRANT_A;
        else if (B_VALID)       state_d = GRANT_B;
      end
      GRANT_A: begin
        // Release on requester withdrawal (even while Z is stalled) or on the
        // final beat of a burst.
        if (!A_VALID || (accept_a && count_q == LAST_BEAT)) begin
          last_d  = 1'b0;
          count_d = '0;
`ifdef FIXED_PRIO_EN
          if (A_VALID)      state_d = GRANT_A;
          else if (B_VALID) state_d = GRANT_B;
          else              state_d = IDLE;
`else
          if (B_VALID)      state_d = GRANT_B;
          else if (A_VALID) state_d = GRANT_A;
          else              state_d = IDLE;
`endif
        end else if (accept_a) begin
          count_d = count_q + CW'(1);
        end
      end
      GRANT_B: begin
        if (!B_VALID || (accept_b && count_q == LAST_BEAT)) begin
          last_d  = 1'b1;
          count_d = '0;
          if (A_VALID)      state_d = GRANT_A;
          else if (B_VALID) state_d = GRANT_B;
          else              state_d = IDLE;
        end else if (accept_b) begin
          count_d = count_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // The select follows the grant. In IDLE it holds the last granted side.
  always_comb begin
    s0_d = S0;
    if (state_d == GRANT_A)      s0_d = 1'b0;
    else if (state_d == GRANT_B) s0_d = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so that every flop
  // samples pre-edge values. All state here is small control/data flops, so
  // every one is reset, including Z_DATA.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      count_q <= '0;
      last_q  <= 1'b1;
      S0      <= 1'b0;
      Z_VALID <= 1'b0;
      Z_DATA  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
      S0      <= s0_d;
      if (accept_a || accept_b) begin
        Z_VALID <= 1'b1;
        Z_DATA  <= accept_b ? B_DATA : A_DATA;
      end else if (load_en) begin
        Z_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_2to1_arb.sv
// -----------------------------------------------------------------------------
// tb_mux_2to1_arb
//
// Directed bench for mux_2to1_arb with WIDTH = 8 and MAX_BURST = 4.
// Inputs change 1 time unit after the rising edge. Outputs are sampled in the
// same window, well away from the next edge.
//
// Build with FIXED_PRIO_EN defined to check the fixed-priority variant.
// -----------------------------------------------------------------------------
module tb_mux_2to1_arb;

  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             A_VALID, B_VALID, Z_READY;
  logic             A_READY, B_READY, Z_VALID, S0;
  logic [WIDTH-1:0] A_DATA, B_DATA, Z_DATA;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  mux_2to1_arb #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .A_VALID(A_VALID),
    .A_READY(A_READY),
    .A_DATA (A_DATA),
    .B_VALID(B_VALID),
    .B_READY(B_READY),
    .B_DATA (B_DATA),
    .Z_VALID(Z_VALID),
    .Z_READY(Z_READY),
    .Z_DATA (Z_DATA),
    .S0     (S0)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST_N   = 1'b0;
    A_VALID = 1'b0;
    B_VALID = 1'b0;
    Z_READY = 1'b0;
    A_DATA  = '0;
    B_DATA  = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    step();
  endtask

  // Reset state, then an asynchronous reset in the middle of a B burst.
  task automatic test_reset();
    apply_reset();
    checks++; if (Z_VALID !== 1'b0) begin errors++; $display("FAIL reset_z_valid got=%b exp=0", Z_VALID); end
    checks++; if (Z_DATA !== 8'h00) begin errors++; $display("FAIL reset_z_data got=%h exp=00", Z_DATA); end
    checks++; if (S0 !== 1'b0) begin errors++; $display("FAIL reset_s0 got=%b exp=0", S0); end
    B_VALID = 1'b1; B_DATA = 8'h5A; Z_READY = 1'b1;
    step();
    step();
    checks++; if (S0 !== 1'b1 || Z_VALID !== 1'b1) begin errors++; $display("FAIL reset_pre_burst s0=%b z_valid=%b exp=1/1", S0, Z_VALID); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if (S0 !== 1'b0) begin errors++; $display("FAIL reset_async_s0 got=%b exp=0", S0); end
    checks++; if (Z_VALID !== 1'b0) begin errors++; $display("FAIL reset_async_z_valid got=%b exp=0", Z_VALID); end
    checks++; if (Z_DATA !== 8'h00) begin errors++; $display("FAIL reset_async_z_data got=%h exp=00", Z_DATA); end
    checks++; if (A_READY !== 1'b0 || B_READY !== 1'b0) begin errors++; $display("FAIL reset_async_ready a=%b b=%b exp=0/0", A_READY, B_READY); end
  endtask

  // A alone: five beats. This covers the burst restart after the fourth beat.
  task automatic test_a_only();
    logic [WIDTH-1:0] d [5];
    d = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h00};
    apply_reset();
    A_VALID = 1'b1; A_DATA = d[0]; Z_READY = 1'b1;
    #1;
    checks++; if (A_READY !== 1'b0) begin errors++; $display("FAIL a_only_idle_ready got=%b exp=0", A_READY); end
    step();
    for (int i = 0; i < 5; i++) begin
      A_DATA = d[i];
      #1;
      checks++; if (A_READY !== 1'b1 || S0 !== 1'b0) begin errors++; $display("FAIL a_only_ready beat=%0d a_ready=%b s0=%b exp=1/0", i, A_READY, S0); end
      step();
      checks++; if (Z_VALID !== 1'b1 || Z_DATA !== d[i]) begin errors++; $display("FAIL a_only_z beat=%0d z_valid=%b z_data=%h exp=1/%h", i, Z_VALID, Z_DATA, d[i]); end
    end
    A_VALID = 1'b0;
    step();
    checks++; if (Z_VALID !== 1'b0 || A_READY !== 1'b0 || S0 !== 1'b0) begin errors++; $display("FAIL a_only_idle z_valid=%b a_ready=%b s0=%b exp=0/0/0", Z_VALID, A_READY, S0); end
  endtask

  // Both requesters stay valid. The round-robin build alternates 4 A beats
  // and 4 B beats. The fixed-priority build stays on A.
  task automatic test_contention();
    int na, nb;
    logic side_b;
    logic [WIDTH-1:0] exp;
    na = 0; nb = 0;
    apply_reset();
    A_VALID = 1'b1; B_VALID = 1'b1; Z_READY = 1'b1;
    A_DATA = 8'h10; B_DATA = 8'h80;
    step();
    for (int i = 0; i < 16; i++) begin
`ifdef FIXED_PRIO_EN
      side_b = 1'b0;
`else
      side_b = ((i / MAX_BURST) % 2) == 1;
`endif
      A_DATA = 8'(8'h10 + na);
      B_DATA = 8'(8'h80 + nb);
      #1;
      checks++; if (A_READY !== !side_b || B_READY !== side_b || S0 !== side_b) begin errors++; $display("FAIL contention_grant cycle=%0d a_ready=%b b_ready=%b s0=%b exp_b=%b", i, A_READY, B_READY, S0, side_b); end
      if (side_b) begin exp = B_DATA; nb++; end
      else begin exp = A_DATA; na++; end
      step();
      checks++; if (Z_VALID !== 1'b1 || Z_DATA !== exp) begin errors++; $display("FAIL contention_z cycle=%0d z_valid=%b z_data=%h exp=1/%h", i, Z_VALID, Z_DATA, exp); end
    end
  endtask

  // Z stalls for 3 cycles with a beat held. No beat may be lost or duplicated.
  task automatic test_backpressure();
    apply_reset();
    A_VALID = 1'b1; A_DATA = 8'h11; Z_READY = 1'b1;
    step();
    checks++; if (A_READY !== 1'b1) begin errors++; $display("FAIL bp_grant a_ready=%b exp=1", A_READY); end
    step();
    checks++; if (Z_VALID !== 1'b1 || Z_DATA !== 8'h11) begin errors++; $display("FAIL bp_first z_valid=%b z_data=%h exp=1/11", Z_VALID, Z_DATA); end
    A_DATA = 8'h22; Z_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (A_READY !== 1'b0 || Z_VALID !== 1'b1 || Z_DATA !== 8'h11) begin errors++; $display("FAIL bp_stall cycle=%0d a_ready=%b z_valid=%b z_data=%h exp=0/1/11", i, A_READY, Z_VALID, Z_DATA); end
      step();
    end
    Z_READY = 1'b1;
    #1;
    checks++; if (A_READY !== 1'b1 || Z_DATA !== 8'h11) begin errors++; $display("FAIL bp_resume a_ready=%b z_data=%h exp=1/11", A_READY, Z_DATA); end
    step();
    checks++; if (Z_VALID !== 1'b1 || Z_DATA !== 8'h22) begin errors++; $display("FAIL bp_second z_valid=%b z_data=%h exp=1/22", Z_VALID, Z_DATA); end
    A_DATA = 8'h33;
    step();
    checks++; if (Z_VALID !== 1'b1 || Z_DATA !== 8'h33) begin errors++; $display("FAIL bp_third z_valid=%b z_data=%h exp=1/33", Z_VALID, Z_DATA); end
    A_VALID = 1'b0;
    step();
    checks++; if (Z_VALID !== 1'b0) begin errors++; $display("FAIL bp_drain z_valid=%b exp=0", Z_VALID); end
  endtask

  // B is granted and drops after 2 beats while A waits. A is granted on the
  // next edge.
  task automatic test_b_drop();
    apply_reset();
    B_VALID = 1'b1; B_DATA = 8'hB1; Z_READY = 1'b1;
    step();
    checks++; if (S0 !== 1'b1 || B_READY !== 1'b1 || A_READY !== 1'b0) begin errors++; $display("FAIL bdrop_grant s0=%b b_ready=%b a_ready=%b exp=1/1/0", S0, B_READY, A_READY); end
    step();
    checks++; if (Z_VALID !== 1'b1 || Z_DATA !== 8'hB1) begin errors++; $display("FAIL bdrop_beat0 z_valid=%b z_data=%h exp=1/b1", Z_VALID, Z_DATA); end
    B_DATA = 8'hB2;
    step();
    checks++; if (Z_DATA !== 8'hB2 || S0 !== 1'b1) begin errors++; $display("FAIL bdrop_beat1 z_data=%h s0=%b exp=b2/1", Z_DATA, S0); end
    B_VALID = 1'b0; A_VALID = 1'b1; A_DATA = 8'hA1;
    #1;
    checks++; if (A_READY !== 1'b0) begin errors++; $display("FAIL bdrop_a_wait a_ready=%b exp=0", A_READY); end
    step();
    checks++; if (S0 !== 1'b0 || Z_VALID !== 1'b0 || A_READY !== 1'b1 || B_READY !== 1'b0) begin errors++; $display("FAIL bdrop_switch s0=%b z_valid=%b a_ready=%b b_ready=%b exp=0/0/1/0", S0, Z_VALID, A_READY, B_READY); end
    step();
    checks++; if (Z_VALID !== 1'b1 || Z_DATA !== 8'hA1) begin errors++; $display("FAIL bdrop_a_beat z_valid=%b z_data=%h exp=1/a1", Z_VALID, Z_DATA); end
  endtask

  // A withdraws while Z is stalled. The grant still moves to B, and B's beat
  // waits for Z to drain.
  task automatic test_stall_release();
    apply_reset();
    A_VALID = 1'b1; A_DATA = 8'hC1; Z_READY = 1'b1;
    step();
    step();
    Z_READY = 1'b0; A_VALID = 1'b0; B_VALID = 1'b1; B_DATA = 8'hD1;
    step();
    checks++; if (S0 !== 1'b1 || B_READY !== 1'b0 || Z_DATA !== 8'hC1 || Z_VALID !== 1'b1) begin errors++; $display("FAIL stall_switch s0=%b b_ready=%b z_valid=%b z_data=%h exp=1/0/1/c1", S0, B_READY, Z_VALID, Z_DATA); end
    Z_READY = 1'b1;
    #1;
    checks++; if (B_READY !== 1'b1) begin errors++; $display("FAIL stall_resume b_ready=%b exp=1", B_READY); end
    step();
    checks++; if (Z_VALID !== 1'b1 || Z_DATA !== 8'hD1) begin errors++; $display("FAIL stall_b_beat z_valid=%b z_data=%h exp=1/d1", Z_VALID, Z_DATA); end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_contention();
    test_backpressure();
    test_b_drop();
    test_stall_release();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
